// File: rtl/mcoi_display_driver_pkg.sv
// Shared types and constants for the front-panel display driver.
package DisplayPkg;

  localparam int unsigned NUM_COLUMNS = 8;
  localparam int unsigned COL_W       = 3;

  typedef logic [COL_W-1:0] column_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    SELECT,
    ON
  } display_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t_display.sv
// Pin bundle towards the LED driver chain.
interface t_display;
  import DisplayPkg::*;

  logic    latch;
  logic    blank;
  column_t csel;
  logic    sclk;
  logic    sin;

  modport producer (output latch, blank, csel, sclk, sin);
  modport consumer (input  latch, blank, csel, sclk, sin);
endinterface

// File: rtl/display_shifter.sv
// Parallel-load shift register with sclk divider; shifts MSB first.
module display_shifter
  import DisplayPkg::*;
#(
  parameter int unsigned ROW_BITS = 16,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic [ROW_BITS-1:0] load_data,
  output logic                sclk,
  output logic                sin,
  output logic                done_c
);

  localparam int unsigned BIT_W = cnt_width(ROW_BITS);
  localparam int unsigned DIV_W = cnt_width(CLK_DIV);

  logic                active_q;
  logic [ROW_BITS-1:0] sreg_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DIV_W-1:0]    div_q;
  logic                sclk_q;
  logic                sin_q;
  logic                div_end;
  logic                bit_end;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_end = (bit_q == BIT_W'(ROW_BITS - 1));

  // High in the final cycle of the final bit's sclk-high phase.
  assign done_c = active_q && sclk_q && div_end && bit_end;

  assign sclk = sclk_q;
  assign sin  = sin_q;

  // Each bit: sclk low for CLK_DIV cycles, high for CLK_DIV cycles; sin changes only at bit start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active_q <= 1'b0;
      sreg_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      sin_q    <= 1'b0;
    end else if (load) begin
      active_q <= 1'b1;
      sreg_q   <= load_data;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      sin_q    <= load_data[ROW_BITS-1];
    end else if (active_q) begin
      if (!div_end) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          if (bit_end) begin
            active_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + BIT_W'(1);
            sreg_q <= {sreg_q[ROW_BITS-2:0], 1'b0};
            sin_q  <= sreg_q[ROW_BITS-2];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mcoi_display_driver.sv
// Double-buffered 8-column LED scan driver: blank, shift, latch, select, light.
module mcoi_display_driver
  import DisplayPkg::*;
#(
  parameter int unsigned ROW_BITS  = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned ON_CYCLES = 1000
) (
  input  logic                clk_ix,
  input  logic                rstn_ix,
  input  logic                enable_i,
  input  logic                wr_en_i,
  input  column_t             wr_addr_ib,
  input  logic [ROW_BITS-1:0] wr_data_ib,
  input  logic                commit_i,
  output logic                commit_pending_o,
  output logic                frame_done_o,
  t_display.producer          display_x
);

  localparam int unsigned CNT_MAX  = (ON_CYCLES > CLK_DIV) ? ON_CYCLES : CLK_DIV;
  localparam int unsigned CNT_W    = cnt_width(CNT_MAX);
  localparam column_t     LAST_COL = column_t'(NUM_COLUMNS - 1);

  display_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  column_t             col_q, col_d;
  column_t             csel_q, csel_d;
  logic                blank_q, blank_d;
  logic                latch_q, latch_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic                load_c;
  logic                copy_c;
  logic                shift_done_c;
  logic                sclk;
  logic                sin;
  logic [ROW_BITS-1:0] front_q [NUM_COLUMNS];
  logic [ROW_BITS-1:0] back_q  [NUM_COLUMNS];

  // Serialiser for the column being loaded.
  display_shifter #(
    .ROW_BITS (ROW_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clk       (clk_ix),
    .rstn      (rstn_ix),
    .load      (load_c),
    .load_data (front_q[col_q]),
    .sclk      (sclk),
    .sin       (sin),
    .done_c    (shift_done_c)
  );

  // Next-state, counters, and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    load_c       = 1'b0;
    copy_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done_c) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SELECT: begin
        state_d = ON;
        cnt_d   = '0;
      end
      ON: begin
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          col_d        = col_q + column_t'(1);
          frame_done_d = (col_q == LAST_COL);
          copy_c       = (col_q == LAST_COL) && pending_q;
          state_d      = enable_i ? LOAD : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    blank_d   = (state_d != ON);
    latch_d   = (state_d == LATCH);
    csel_d    = (state_d == SELECT) ? col_q : csel_q;
    pending_d = commit_i ? 1'b1 : (copy_c ? 1'b0 : pending_q);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_ix) begin
    if (!rstn_ix) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      csel_q       <= '0;
      blank_q      <= 1'b1;
      latch_q      <= 1'b0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      csel_q       <= csel_d;
      blank_q      <= blank_d;
      latch_q      <= latch_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame buffers: the copy reads back before this edge's write lands.
  always_ff @(posedge clk_ix) begin
    if (!rstn_ix) begin
      front_q <= '{default: '0};
      back_q  <= '{default: '0};
    end else begin
      if (copy_c)  front_q <= back_q;
      if (wr_en_i) back_q[wr_addr_ib] <= wr_data_ib;
    end
  end

  assign display_x.blank = blank_q;
  assign display_x.latch = latch_q;
  assign display_x.csel  = csel_q;
  assign display_x.sclk  = sclk;
  assign display_x.sin   = sin;
  assign commit_pending_o = pending_q;
  assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_mcoi_display_driver.sv
// Bench for mcoi_display_driver: timeline reference model, directed scenarios, random traffic.
module tb_mcoi_display_driver;

  localparam int RB  = 16;
  localparam int CD  = 2;
  localparam int ONC = 10;
  localparam int S   = 2 * CD * RB;
  localparam int P   = 1 + S + CD + 1 + ONC;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        commit_pending;
  logic        frame_done;

  t_display disp ();

  mcoi_display_driver #(
    .ROW_BITS  (RB),
    .CLK_DIV   (CD),
    .ON_CYCLES (ONC)
  ) dut (
    .clk_ix           (clk),
    .rstn_ix          (rstn),
    .enable_i         (enable),
    .wr_en_i          (wr_en),
    .wr_addr_ib       (wr_addr),
    .wr_data_ib       (wr_data),
    .commit_i         (commit),
    .commit_pending_o (commit_pending),
    .frame_done_o     (frame_done),
    .display_x        (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within a column timeline plus the two buffers.
  bit          chk_en = 0;
  bit          m_run;
  int          m_t;
  logic [2:0]  m_col;
  logic [2:0]  m_csel;
  logic        m_sin;
  logic        m_pend;
  logic        m_fd;
  logic [15:0] m_data;
  logic [15:0] m_front [8];
  logic [15:0] m_back  [8];
  logic        e_blank, e_latch, e_sclk;

  always @(posedge clk) begin
    bit fd;
    bit copy;
    int k;
    if (!rstn) begin
      chk_en = 1;
      m_run  = 0;
      m_t    = 0;
      m_col  = 3'd0;
      m_csel = 3'd0;
      m_sin  = 1'b0;
      m_pend = 1'b0;
      m_fd   = 1'b0;
      m_data = 16'h0;
      for (int i = 0; i < 8; i++) begin
        m_front[i] = 16'h0;
        m_back[i]  = 16'h0;
      end
    end else begin
      fd   = 0;
      copy = 0;
      if (m_run) begin
        if (m_t == P - 1) begin
          fd    = (m_col == 3'd7);
          copy  = fd && m_pend;
          m_col = m_col + 3'd1;
          m_run = enable;
          m_t   = 0;
        end else begin
          m_t++;
        end
      end else if (enable) begin
        m_run = 1;
        m_t   = 0;
      end
      if (copy) m_front = m_back;
      if (commit) m_pend = 1'b1;
      else if (copy) m_pend = 1'b0;
      if (wr_en) m_back[wr_addr] = wr_data;
      m_fd = fd;
      if (m_run && m_t == 0) m_data = m_front[m_col];
    end
    e_blank = 1'b1;
    e_latch = 1'b0;
    e_sclk  = 1'b0;
    if (m_run) begin
      if (m_t >= 1 && m_t <= S) begin
        k      = m_t - 1;
        e_sclk = ((k % (2 * CD)) >= CD);
        m_sin  = m_data[RB - 1 - k / (2 * CD)];
      end else if (m_t > S && m_t <= S + CD) begin
        e_latch = 1'b1;
        m_sin   = m_data[0];
      end else if (m_t == S + CD + 1) begin
        m_csel = m_col;
      end else if (m_t > S + CD + 1) begin
        e_blank = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("blank",          32'(disp.blank),     32'(e_blank));
      check("latch",          32'(disp.latch),     32'(e_latch));
      check("sclk",           32'(disp.sclk),      32'(e_sclk));
      check("sin",            32'(disp.sin),       32'(m_sin));
      check("csel",           32'(disp.csel),      32'(m_csel));
      check("commit_pending", 32'(commit_pending), 32'(m_pend));
      check("frame_done",     32'(frame_done),     32'(m_fd));
    end
  end

  task automatic write_col(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Stops at the LOAD cycle of column c (blank rising while csel shows the previous column).
  task automatic wait_load(input int c);
    logic pb;
    bit   ok;
    pb = disp.blank;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (disp.blank && !pb && disp.csel == 3'((c + 7) % 8)) begin
        ok = 1;
        break;
      end
      pb = disp.blank;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_load col %0d: timed out, expected a LOAD within 2000 cycles", c);
    end
  endtask

  // Observes one column period starting at its LOAD cycle.
  task automatic capture(input int drop_at, output logic [15:0] bits, output int lat,
                         output int onc, output logic [2:0] cs);
    logic ps;
    ps   = disp.sclk;
    bits = 16'h0;
    lat  = 0;
    onc  = 0;
    cs   = 3'd0;
    for (int i = 0; i < P; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (disp.sclk && !ps) bits = {bits[14:0], disp.sin};
      ps = disp.sclk;
      if (disp.latch) lat++;
      if (!disp.blank) begin
        onc++;
        cs = disp.csel;
      end
      @(negedge clk);
    end
  endtask

  logic [15:0] bits;
  logic [15:0] frame_b [8];
  logic [2:0]  cs;
  int          lat, onc;

  initial begin
    int fd_cnt, fd_first, fd_second, nseen;
    logic pb;
    rstn    = 1'b0;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 16'h0;
    commit  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 100; i++) begin
      check("idle_outputs", 32'({disp.blank, disp.latch, disp.sclk, disp.csel}), 32'b100000);
      @(negedge clk);
    end

    // Single column: data reaches the display after the first frame boundary.
    write_col(0, 16'hA5C3);
    pulse_commit();
    check("pending_after_commit", 32'(commit_pending), 32'd1);
    enable = 1'b1;
    wait_load(0);
    capture(-1, bits, lat, onc, cs);
    check("col0_sin_bits", 32'(bits), 32'h0000A5C3);
    check("col0_latch_cycles", 32'(lat), 32'd2);
    check("col0_on_cycles", 32'(onc), 32'd10);
    check("col0_csel", 32'(cs), 32'd0);

    // Full frame: csel order and frame_done period.
    for (int k = 0; k < 8; k++) write_col(k, 16'(16'h1111 * (k + 1)));
    pulse_commit();
    wait_load(0);
    fd_cnt = 0; fd_first = -1; fd_second = -1; nseen = 0;
    pb = disp.blank;
    for (int i = 0; i < 9 * P; i++) begin
      if (!disp.blank && pb) begin
        check("csel_order", 32'(disp.csel), 32'(nseen % 8));
        nseen++;
      end
      pb = disp.blank;
      if (frame_done) begin
        if (fd_cnt == 0) fd_first = i;
        else if (fd_cnt == 1) fd_second = i;
        fd_cnt++;
      end
      @(negedge clk);
    end
    check("columns_seen", 32'(nseen), 32'd9);
    check("frame_done_count", 32'(fd_cnt), 32'd2);
    check("frame_done_period", 32'(fd_second - fd_first), 32'd624);

    // Double buffering: uncommitted writes stay invisible.
    for (int k = 0; k < 8; k++) begin
      frame_b[k] = 16'($urandom);
      write_col(k, frame_b[k]);
    end
    for (int f = 0; f < 2; f++) begin
      wait_load(0);
      capture(-1, bits, lat, onc, cs);
      check("frame_a_held", 32'(bits), 32'h00001111);
    end
    pulse_commit();
    wait_load(0);
    capture(-1, bits, lat, onc, cs);
    check("frame_b_col0", 32'(bits), 32'(frame_b[0]));

    // Boundary collision: commit and write in the exact copy cycle.
    write_col(3, 16'h0C0C);
    pulse_commit();
    for (int i = 0; i < 2000; i++) begin
      if (!disp.blank && disp.csel == 3'd7) break;
      @(negedge clk);
    end
    repeat (ONC - 1) @(negedge clk);
    commit  = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 16'hFFFF;
    @(negedge clk);
    commit = 1'b0;
    wr_en  = 1'b0;
    check("pending_reset_in_copy", 32'(commit_pending), 32'd1);
    check("frame_done_at_wrap", 32'(frame_done), 32'd1);
    wait_load(3);
    capture(-1, bits, lat, onc, cs);
    check("collision_old_col3", 32'(bits), 32'h00000C0C);
    wait_load(3);
    capture(-1, bits, lat, onc, cs);
    check("collision_new_col3", 32'(bits), 32'h0000FFFF);
    check("pending_cleared", 32'(commit_pending), 32'd0);

    // Enable drop mid-shift: column finishes, then idle, then resume at next column.
    wait_load(2);
    capture(10, bits, lat, onc, cs);
    check("drop_col2_bits", 32'(bits), 32'(frame_b[2]));
    check("drop_col2_on", 32'(onc), 32'd10);
    repeat (20) @(negedge clk);
    check("drop_idle", 32'({disp.blank, disp.csel}), 32'b1010);
    enable = 1'b1;
    @(negedge clk);
    capture(-1, bits, lat, onc, cs);
    check("resume_csel", 32'(cs), 32'd3);
    check("resume_bits", 32'(bits), 32'h0000FFFF);

    // Reset mid-shift.
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("reset_mid_shift", 32'({disp.blank, disp.latch, disp.sclk, disp.sin, disp.csel,
                                  commit_pending, frame_done}), 32'b100000000);
    rstn = 1'b1;
    @(negedge clk);
    capture(-1, bits, lat, onc, cs);
    check("after_reset_bits", 32'(bits), 32'd0);
    check("after_reset_csel", 32'(cs), 32'd0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      commit  = ($urandom_range(0, 59) == 0);
      rstn    = ($urandom_range(0, 2499) != 0);
      @(negedge clk);
    end
    rstn   = 1'b1;
    wr_en  = 1'b0;
    commit = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
